rom_ctrl: RTL and testbench

Parametrised read-only memory bus slave, the next generation of the team's boot ROM. Adds configurable data width, depth and wait states, back-to-back single-cycle reads, early abort on strobe withdrawal, and an error response for writes and out-of-range addresses. Sits on the system bus as a slave behind the bus address decoder, which supplies its chip select.

---
 rtl/rom_ctrl_pkg.sv | 35 +++
 rtl/rom_ctrl_array.sv | 34 +++
 rtl/rom_ctrl.sv | 134 +++++++++++++
 tb/tb_rom_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_ctrl_pkg.sv
// Shared definitions for the ROM bus slave: state codes, default widths,
// bus polarity constants and the built-in memory image.
package rom_ctrl_pkg;

  // Controller state encodings
  localparam logic [1:0] RomIdle = 2'b00;
  localparam logic [1:0] RomWait = 2'b01;
  localparam logic [1:0] RomAck  = 2'b10;

  // Default bus widths and wait counter width
  localparam int unsigned RomAddrBus  = 11;
  localparam int unsigned WordDataBus = 32;
  localparam int unsigned WaitCntW    = 4;

  // Active-low bus signal levels
  localparam logic Enable_  = 1'b0;
  localparam logic Disable_ = 1'b1;

  // Image content for word idx. The ramp image returns the word index; the boot
  // image carries a marker word at index 5 and a fixed pattern elsewhere. The
  // upper half is the inverse of the lower half so 64-bit builds see every bit.
  function automatic logic [63:0] image_word(input int unsigned idx, input bit ramp);
    logic [31:0] w;
    if (ramp) begin
      return 64'(idx);
    end
    if (idx == 32'd5) begin
      w = 32'hDEAD_BEEF;
    end else begin
      w = (idx * 32'h0101_0101) ^ 32'hA5A5_A5A5;
    end
    return {~w, w};
  endfunction

endpackage

// File: rtl/rom_ctrl_array.sv
// Vendor-independent synchronous-read block ROM with one cycle of read latency.
// The full 2^ADDR_W space is populated; words at or above DEPTH read as zero.
module rom_array
  import rom_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = WordDataBus,
  parameter int unsigned ADDR_W    = RomAddrBus,
  parameter int unsigned DEPTH     = 2048,
  parameter string       INIT_FILE = "rom.hex"
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned Words = 2 ** ADDR_W;
  localparam bit          Ramp  = (INIT_FILE == "ramp.hex");

  logic [DATA_W-1:0] rom [Words];

  for (genvar i = 0; i < Words; i++) begin : g_word
    if (i < DEPTH) begin : g_impl
      assign rom[i] = DATA_W'(image_word(i, Ramp));
    end else begin : g_empty
      assign rom[i] = '0;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    rd_data <= rom[addr];
  end

endmodule

// File: rtl/rom_ctrl.sv
// ROM bus slave: accepts strobed reads, inserts WAIT_CYC wait states, pulses
// rdy_ once per access and flags writes and out-of-range reads with err.
module rom_ctrl
  import rom_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = WordDataBus,
  parameter int unsigned ADDR_W    = RomAddrBus,
  parameter int unsigned DEPTH     = 2048,
  parameter int unsigned WAIT_CYC  = 0,
  parameter string       INIT_FILE = "rom.hex"
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_,
  input  logic              as_,
  input  logic              rw_,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rdy_,
  output logic              err
);

  logic [1:0]          state_q, state_d;
  logic [WaitCntW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rdy_q, err_q;

  logic                req;
  logic                oor;
  logic [ADDR_W-1:0]   arr_addr;
  logic [DATA_W-1:0]   arr_data;

  assign req = (cs_ == Enable_) && (as_ == Enable_);
  assign oor = 32'(addr_q) >= DEPTH;

  // While waiting, keep the array pointed at the latched address so its output
  // is the requested word when the ACK cycle is reached.
  assign arr_addr = (state_q == RomWait) ? addr_q : addr;

  rom_array #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .INIT_FILE(INIT_FILE)
  ) u_rom_array (
    .clk    (clk),
    .addr   (arr_addr),
    .rd_data(arr_data)
  );

  // Next-state logic for the FSM, wait counter and request latch
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    case (state_q)
      RomIdle, RomAck: begin
        if (req) begin
          addr_d = addr;
          rw_d   = rw_;
          if (WAIT_CYC == 0) begin
            state_d = RomAck;
          end else begin
            state_d = RomWait;
            cnt_d   = WaitCntW'(WAIT_CYC - 1);
          end
        end else begin
          state_d = RomIdle;
        end
      end
      RomWait: begin
        // Strobe withdrawal wins over an expiring counter
        if (!req) begin
          state_d = RomIdle;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = RomAck;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = RomIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, counter and request latch registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RomIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
    end
  end

  // Output registers: one rdy_ pulse per ACK, data only for reads
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
      rdy_q     <= Disable_;
      err_q     <= 1'b0;
    end else if (state_q == RomAck) begin
      rdy_q <= Enable_;
      if (!rw_q) begin
        err_q <= 1'b1;
      end else if (oor) begin
        err_q     <= 1'b1;
        rd_data_q <= '0;
      end else begin
        err_q     <= 1'b0;
        rd_data_q <= arr_data;
      end
    end else begin
      rdy_q <= Disable_;
      err_q <= 1'b0;
    end
  end

  assign rd_data = rd_data_q;
  assign rdy_    = rdy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_rom_ctrl.sv
// Bench for rom_ctrl: three configurations share one bus, each selected by its
// own chip select. Expected responses come from a transaction-level model.
module tb_rom_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_a, cs_b, cs_c;
  logic        as_, rw_;
  logic [10:0] addr;
  logic [31:0] rd_a, rd_b;
  logic [15:0] rd_c;
  logic        rdy_a, rdy_b, rdy_c;
  logic        err_a, err_b, err_c;

  int checks = 0;
  int errors = 0;

  // Per-configuration parameters: 0 = 32b/DEPTH 1000/no waits,
  // 1 = 32b/full depth/3 waits, 2 = 16b ramp/8-bit address/2 waits.
  int unsigned depth_cfg [3] = '{1000, 2048, 256};
  int unsigned wait_cfg  [3] = '{0, 3, 2};
  logic [31:0] model_rd  [3];

  always #5 clk = ~clk;

  rom_ctrl #(
    .DATA_W(32), .ADDR_W(11), .DEPTH(1000), .WAIT_CYC(0), .INIT_FILE("rom.hex")
  ) u_dut_a (
    .clk(clk), .reset(reset), .cs_(cs_a), .as_(as_), .rw_(rw_), .addr(addr),
    .rd_data(rd_a), .rdy_(rdy_a), .err(err_a)
  );

  rom_ctrl #(
    .DATA_W(32), .ADDR_W(11), .DEPTH(2048), .WAIT_CYC(3), .INIT_FILE("rom.hex")
  ) u_dut_b (
    .clk(clk), .reset(reset), .cs_(cs_b), .as_(as_), .rw_(rw_), .addr(addr),
    .rd_data(rd_b), .rdy_(rdy_b), .err(err_b)
  );

  rom_ctrl #(
    .DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYC(2), .INIT_FILE("ramp.hex")
  ) u_dut_c (
    .clk(clk), .reset(reset), .cs_(cs_c), .as_(as_), .rw_(rw_), .addr(addr[7:0]),
    .rd_data(rd_c), .rdy_(rdy_c), .err(err_c)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Boot image word as defined for the test ROM
  function automatic logic [31:0] boot_word(input int unsigned i);
    if (i == 5) return 32'hDEAD_BEEF;
    return (i * 32'h0101_0101) ^ 32'hA5A5_A5A5;
  endfunction

  function automatic logic [31:0] get_data(input int d);
    case (d)
      0:       return rd_a;
      1:       return rd_b;
      default: return {16'h0, rd_c};
    endcase
  endfunction

  function automatic logic get_rdy(input int d);
    case (d)
      0:       return rdy_a;
      1:       return rdy_b;
      default: return rdy_c;
    endcase
  endfunction

  function automatic logic get_err(input int d);
    case (d)
      0:       return err_a;
      1:       return err_b;
      default: return err_c;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic select(input int d, input logic v);
    cs_a = 1'b1;
    cs_b = 1'b1;
    cs_c = 1'b1;
    case (d)
      0:       cs_a = v;
      1:       cs_b = v;
      default: cs_c = v;
    endcase
  endtask

  task automatic release_bus();
    cs_a = 1'b1;
    cs_b = 1'b1;
    cs_c = 1'b1;
    as_  = 1'b1;
    rw_  = 1'b1;
  endtask

  // Expected response of one access; updates the remembered read data
  task automatic model(input int d, input int unsigned a, input logic rw,
                       output logic e, output logic [31:0] dat);
    if (!rw) begin
      e   = 1'b1;
      dat = model_rd[d];
    end else if (a >= depth_cfg[d]) begin
      e   = 1'b1;
      dat = 32'h0;
    end else begin
      e   = 1'b0;
      dat = (d == 2) ? {16'h0, a[15:0]} : boot_word(a);
    end
    model_rd[d] = dat;
  endtask

  // One isolated access, strobe held through the wait states and then released
  task automatic access(input int d, input int unsigned a, input logic rw, input string tag);
    logic        e;
    logic [31:0] dat;
    model(d, a, rw, e, dat);
    @(negedge clk);
    select(d, 1'b0);
    as_  = 1'b0;
    rw_  = rw;
    addr = 11'(a);
    for (int k = 0; k <= int'(wait_cfg[d]); k++) begin
      @(negedge clk);
      check({tag, "_early_rdy"}, 32'(get_rdy(d)), 32'd1);
    end
    release_bus();
    @(negedge clk);
    check({tag, "_rdy"}, 32'(get_rdy(d)), 32'd0);
    check({tag, "_err"}, 32'(get_err(d)), 32'(e));
    check({tag, "_data"}, get_data(d), dat);
    @(negedge clk);
    check({tag, "_rdy_end"}, 32'(get_rdy(d)), 32'd1);
    check({tag, "_err_end"}, 32'(get_err(d)), 32'd0);
  endtask

  // Strobe held low on configuration 0 with a new request every cycle
  task automatic burst(input int n, input logic [10:0] addrs [16], input logic rws [16]);
    logic        e    [16];
    logic [31:0] dat  [16];
    for (int i = 0; i < n; i++) model(0, addrs[i], rws[i], e[i], dat[i]);
    @(negedge clk);
    select(0, 1'b0);
    as_  = 1'b0;
    rw_  = rws[0];
    addr = addrs[0];
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("burst_first_rdy", 32'(rdy_a), 32'd1);
      end else begin
        check("burst_rdy", 32'(rdy_a), 32'd0);
        check("burst_err", 32'(err_a), 32'(e[i-1]));
        check("burst_data", rd_a, dat[i-1]);
      end
      if (i < n - 1) begin
        rw_  = rws[i+1];
        addr = addrs[i+1];
      end else begin
        release_bus();
      end
    end
    @(negedge clk);
    check("burst_last_rdy", 32'(rdy_a), 32'd0);
    check("burst_last_err", 32'(err_a), 32'(e[n-1]));
    check("burst_last_data", rd_a, dat[n-1]);
    @(negedge clk);
    check("burst_end_rdy", 32'(rdy_a), 32'd1);
  endtask

  initial begin
    logic [10:0] ba [16];
    logic        br [16];
    int          d;
    int unsigned a;

    release_bus();
    addr  = '0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) model_rd[i] = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("reset_rdy", 32'(get_rdy(i)), 32'd1);
      check("reset_err", 32'(get_err(i)), 32'd0);
      check("reset_data", get_data(i), 32'h0);
    end

    // Single read of the marker word, then word-level boundary cases
    access(0, 5, 1'b1, "single_w5");
    access(0, 10, 1'b0, "write_a10");
    access(0, 1000, 1'b1, "oor_a1000");
    access(0, 999, 1'b1, "last_a999");
    access(0, 10, 1'b0, "write_after_oor");

    // Back-to-back reads of words 0..3, then a random mixed burst
    for (int i = 0; i < 4; i++) begin
      ba[i] = 11'(i);
      br[i] = 1'b1;
    end
    burst(4, ba, br);
    for (int i = 0; i < 12; i++) begin
      ba[i] = 11'($urandom_range(0, 1023));
      br[i] = ($urandom_range(0, 3) != 0);
    end
    burst(12, ba, br);

    // Wait states: normal read, then an access abandoned after two cycles
    access(1, 7, 1'b1, "wait3_a7");
    @(negedge clk);
    select(1, 1'b0);
    as_  = 1'b0;
    addr = 11'd9;
    repeat (2) @(negedge clk);
    release_bus();
    repeat (5) begin
      @(negedge clk);
      check("abort_no_rdy", 32'(rdy_b), 32'd1);
      check("abort_hold_data", rd_b, model_rd[1]);
    end
    access(1, 2047, 1'b1, "after_abort");

    // Width parametrisation on the ramp image
    access(2, 8'h00, 1'b1, "w16_a00");
    access(2, 8'hFF, 1'b1, "w16_aff");
    access(2, 8'h55, 1'b1, "w16_a55");

    // Reset during a wait state discards the access
    @(negedge clk);
    select(2, 1'b0);
    as_  = 1'b0;
    addr = 11'h10;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_rdy", 32'(rdy_c), 32'd1);
    check("midreset_err", 32'(err_c), 32'd0);
    check("midreset_data", {16'h0, rd_c}, 32'h0);
    release_bus();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) model_rd[i] = 32'h0;
    repeat (3) begin
      @(negedge clk);
      check("midreset_no_rdy", 32'(rdy_c), 32'd1);
    end
    access(2, 0, 1'b1, "after_reset_a0");
    access(2, 8'hFF, 1'b1, "after_reset_aff");

    // Randomized isolated accesses across all configurations
    for (int i = 0; i < 30; i++) begin
      d = $urandom_range(0, 2);
      case (d)
        0:       a = $urandom_range(0, 1023);
        1:       a = $urandom_range(0, 2047);
        default: a = $urandom_range(0, 255);
      endcase
      access(d, a, ($urandom_range(0, 3) != 0), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
